spi_object_loader: RTL

Receives octagon object descriptors from the microcontroller over SPI and maintains the 8-entry object table consumed by `videoGen`. It is directly upstream of `videoGen` and replaces the bare `{xpos, ypos}` shift register. Words are written into a shadow table, and a commit command makes the new table active atomically at the next vertical sync. The result is that no frame is ever drawn from a half-updated table.

---
 rtl/spi_object_loader.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/spi_object_loader.sv
// SPI-fed octagon object table: words land in a shadow table, and a COMMIT makes the shadow
// the active table atomically at the next vsync falling edge.
module spi_object_loader #(
    parameter int unsigned NOBJ = 8
) (
    input  logic              vgaclk,
    input  logic              reset_b,
    input  logic              sck,
    input  logic              sdi,
    input  logic              cs_b,
    input  logic              vsync,
    output logic [NOBJ-1:0]   obj_en,
    output logic [10*NOBJ-1:0] obj_x,
    output logic [10*NOBJ-1:0] obj_y,
    output logic [6*NOBJ-1:0] obj_ring,
    output logic              frame_tick,
    output logic [7:0]        word_count,
    output logic              err
);

    // Synchronisers and edge-detect history
    logic sck_m_q, sck_s_q, sck_h_q;
    logic sdi_m_q, sdi_s_q;
    logic cs_m_q, cs_s_q, cs_h_q;
    logic vs_s_q, vs_h_q;

    logic [31:0]        shift_q, shift_d;
    logic [4:0]         cnt_q, cnt_d;
    logic               done_q, done_d;
    logic               pending_q, pending_d;
    logic [NOBJ-1:0]    sh_en_q, sh_en_d;
    logic [10*NOBJ-1:0] sh_x_q, sh_x_d;
    logic [10*NOBJ-1:0] sh_y_q, sh_y_d;
    logic [6*NOBJ-1:0]  sh_ring_q, sh_ring_d;
    logic [NOBJ-1:0]    act_en_q, act_en_d;
    logic [10*NOBJ-1:0] act_x_q, act_x_d;
    logic [10*NOBJ-1:0] act_y_q, act_y_d;
    logic [6*NOBJ-1:0]  act_ring_q, act_ring_d;
    logic               tick_q, tick_d;
    logic [7:0]         wc_q, wc_d;
    logic               err_q, err_d;

    logic               sck_fall, cs_rise, vs_fall, swap;
    logic [1:0]         op;
    logic [2:0]         slot;
    int unsigned        sidx;

    always_comb begin
        sck_fall   = sck_h_q & ~sck_s_q;
        cs_rise    = cs_s_q & ~cs_h_q;
        vs_fall    = vs_h_q & ~vs_s_q;
        swap       = vs_fall & pending_q;
        op         = shift_q[31:30];
        slot       = shift_q[29:27];
        sidx       = 32'(slot);

        shift_d    = shift_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;
        pending_d  = pending_q;
        sh_en_d    = sh_en_q;
        sh_x_d     = sh_x_q;
        sh_y_d     = sh_y_q;
        sh_ring_d  = sh_ring_q;
        act_en_d   = act_en_q;
        act_x_d    = act_x_q;
        act_y_d    = act_y_q;
        act_ring_d = act_ring_q;
        tick_d     = swap;
        wc_d       = wc_q;
        err_d      = err_q;

        if (cs_s_q) begin
            cnt_d = 5'd0;
            if (cs_rise && cnt_q != 5'd0) begin
                err_d = 1'b1;
            end
        end else if (sck_fall) begin
            shift_d = {shift_q[30:0], sdi_s_q};
            cnt_d   = cnt_q + 5'd1;
            done_d  = (cnt_q == 5'd31);
        end

        // Swap reads the registered shadow, so a same-cycle WRITE misses this swap.
        if (swap) begin
            act_en_d   = sh_en_q;
            act_x_d    = sh_x_q;
            act_y_d    = sh_y_q;
            act_ring_d = sh_ring_q;
            pending_d  = 1'b0;
        end

        if (done_q) begin
            case (op)
                2'b00: begin
                    sh_en_d[sidx]           = shift_q[26];
                    sh_x_d[10*sidx +: 10]   = shift_q[25:16];
                    sh_y_d[10*sidx +: 10]   = shift_q[15:6];
                    sh_ring_d[6*sidx +: 6]  = shift_q[5:0];
                    wc_d                    = wc_q + 8'd1;
                end
                2'b01: begin
                    pending_d = 1'b1;
                    wc_d      = wc_q + 8'd1;
                end
                2'b10: begin
                    sh_en_d = '0;
                    wc_d    = wc_q + 8'd1;
                end
                default: err_d = 1'b1;
            endcase
        end
    end

    always_ff @(posedge vgaclk or negedge reset_b) begin
        if (!reset_b) begin
            sck_m_q    <= 1'b1;
            sck_s_q    <= 1'b1;
            sck_h_q    <= 1'b1;
            sdi_m_q    <= 1'b0;
            sdi_s_q    <= 1'b0;
            cs_m_q     <= 1'b1;
            cs_s_q     <= 1'b1;
            cs_h_q     <= 1'b1;
            vs_s_q     <= 1'b1;
            vs_h_q     <= 1'b1;
            shift_q    <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            pending_q  <= 1'b0;
            sh_en_q    <= '0;
            sh_x_q     <= '0;
            sh_y_q     <= '0;
            sh_ring_q  <= '0;
            act_en_q   <= '0;
            act_x_q    <= '0;
            act_y_q    <= '0;
            act_ring_q <= '0;
            tick_q     <= 1'b0;
            wc_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            sck_m_q    <= sck;
            sck_s_q    <= sck_m_q;
            sck_h_q    <= sck_s_q;
            sdi_m_q    <= sdi;
            sdi_s_q    <= sdi_m_q;
            cs_m_q     <= cs_b;
            cs_s_q     <= cs_m_q;
            cs_h_q     <= cs_s_q;
            vs_s_q     <= vsync;
            vs_h_q     <= vs_s_q;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            pending_q  <= pending_d;
            sh_en_q    <= sh_en_d;
            sh_x_q     <= sh_x_d;
            sh_y_q     <= sh_y_d;
            sh_ring_q  <= sh_ring_d;
            act_en_q   <= act_en_d;
            act_x_q    <= act_x_d;
            act_y_q    <= act_y_d;
            act_ring_q <= act_ring_d;
            tick_q     <= tick_d;
            wc_q       <= wc_d;
            err_q      <= err_d;
        end
    end

    assign obj_en     = act_en_q;
    assign obj_x      = act_x_q;
    assign obj_y      = act_y_q;
    assign obj_ring   = act_ring_q;
    assign frame_tick = tick_q;
    assign word_count = wc_q;
    assign err        = err_q;

endmodule
